// File: rtl/temp_pkg.sv
// Shared types and default sizing for the temperature measurement scheduler.
// Consumed by temp_interval_timer and temp_meas_sched.
package temp_pkg;

   localparam int TEMP_WIDTH      = 10;
   localparam int TEMP_INTERVAL_W = 16;
   localparam int TEMP_LOG2_NAVG  = 2;
   localparam int TEMP_TIMEOUT    = 16;

   typedef enum logic [2:0] {
      IDLE,
      KICK,
      WAIT_BUSY,
      WAIT_DONE,
      ACCUM,
      REPORT
   } sched_state_t;

endpackage

// File: rtl/temp_interval_timer.sv
// Periodic burst timer plus the pending-request flag shared with software triggers.
// A new request in the same cycle the scheduler consumes pending is kept.
module temp_interval_timer
   import temp_pkg::*;
#(
   parameter int INTERVAL_W = TEMP_INTERVAL_W
) (
   input  logic                  lfClk,
   input  logic                  rst,
   input  logic                  enable,
   input  logic                  trigger,
   input  logic [INTERVAL_W-1:0] interval,
   input  logic                  pendClr,
   output logic                  pending
);

   logic [INTERVAL_W-1:0] r_cnt;
   logic                  r_pend;
   logic                  w_run;
   logic                  w_tick;

   assign w_run  = enable && (interval != '0);
   assign w_tick = w_run && (r_cnt == interval - 1'b1);

   always_ff @(posedge lfClk) begin
      if (rst) begin
         r_cnt  <= '0;
         r_pend <= 1'b0;
      end else begin
         if (!w_run || w_tick) begin
            r_cnt <= '0;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
         if (trigger || w_tick) begin
            r_pend <= 1'b1;
         end else if (pendClr) begin
            r_pend <= 1'b0;
         end
      end
   end

   assign pending = r_pend;

endmodule

// File: rtl/temp_meas_sched.sv
// Burst scheduler for tempFsm: kicks samples, averages, thresholds, times out.
// Optional min/max tracking under TEMP_SCHED_MINMAX_EN.
module temp_meas_sched
   import temp_pkg::*;
#(
   parameter int WIDTH      = TEMP_WIDTH,
   parameter int INTERVAL_W = TEMP_INTERVAL_W,
   parameter int LOG2_NAVG  = TEMP_LOG2_NAVG,
   parameter int TIMEOUT    = TEMP_TIMEOUT
) (
   input  logic                  lfClk,
   input  logic                  rst,
   input  logic                  enable,
   input  logic                  trigger,
   input  logic [INTERVAL_W-1:0] interval,
   input  logic [WIDTH-1:0]      thrHigh,
   input  logic [WIDTH-1:0]      thrLow,
   input  logic                  clrErr,
   input  logic                  fsmDone,
   input  logic [WIDTH-1:0]      fsmCycles,
   output logic                  fsmStart,
   output logic                  busy,
   output logic [WIDTH-1:0]      result,
   output logic                  resultValid,
   output logic                  alarmHigh,
   output logic                  alarmLow,
   output logic                  timeoutErr
`ifdef TEMP_SCHED_MINMAX_EN
   ,
   input  logic                  clrMinMax,
   output logic [WIDTH-1:0]      minResult,
   output logic [WIDTH-1:0]      maxResult
`endif
);

   localparam int ACC_W = WIDTH + LOG2_NAVG;
   localparam int NAVG  = 1 << LOG2_NAVG;
   localparam int N_W   = LOG2_NAVG + 1;
   localparam int TMO_W = $clog2(TIMEOUT + 1);

   sched_state_t     r_state;
   sched_state_t     w_next;
   logic [ACC_W-1:0] r_acc;
   logic [WIDTH-1:0] r_sample;
   logic [N_W-1:0]   r_n;
   logic [TMO_W-1:0] r_tmo;
   logic [WIDTH-1:0] r_result;
   logic             r_valid;
   logic             r_hi;
   logic             r_lo;
   logic             r_err;
   logic             w_pending;
   logic             w_pendClr;
   logic             w_abort;
   logic             w_last;
   logic             w_tmoHit;
   logic             w_waitEntry;
   logic [WIDTH-1:0] w_avg;

   temp_interval_timer #(
      .INTERVAL_W(INTERVAL_W)
   ) u_timer (
      .lfClk   (lfClk),
      .rst     (rst),
      .enable  (enable),
      .trigger (trigger),
      .interval(interval),
      .pendClr (w_pendClr),
      .pending (w_pending)
   );

   assign w_pendClr = (r_state == IDLE) && w_pending;
   assign w_last    = (r_n == N_W'(NAVG - 1));
   assign w_tmoHit  = (r_tmo == TMO_W'(TIMEOUT - 1));
   assign w_avg     = r_acc[ACC_W-1:LOG2_NAVG];

   always_comb begin
      w_next  = r_state;
      w_abort = 1'b0;
      unique case (r_state)
         IDLE:      if (w_pending) w_next = KICK;
         KICK:      w_next = WAIT_BUSY;
         WAIT_BUSY: begin
            if (!fsmDone) begin
               w_next = WAIT_DONE;
            end else if (w_tmoHit) begin
               w_abort = 1'b1;
               w_next  = IDLE;
            end
         end
         WAIT_DONE: begin
            if (fsmDone) begin
               w_next = ACCUM;
            end else if (w_tmoHit) begin
               w_abort = 1'b1;
               w_next  = IDLE;
            end
         end
         ACCUM:     w_next = w_last ? REPORT : KICK;
         REPORT:    w_next = IDLE;
         default:   w_next = IDLE;
      endcase
   end

   assign w_waitEntry = (w_next != r_state) &&
                        ((w_next == WAIT_BUSY) || (w_next == WAIT_DONE));

   always_ff @(posedge lfClk) begin
      if (rst) begin
         r_state  <= IDLE;
         r_acc    <= '0;
         r_sample <= '0;
         r_n      <= '0;
         r_tmo    <= '0;
         r_result <= '0;
         r_valid  <= 1'b0;
         r_hi     <= 1'b0;
         r_lo     <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         r_state <= w_next;
         r_valid <= 1'b0;
         if (w_pendClr) begin
            r_acc <= '0;
            r_n   <= '0;
         end
         // r_tmo counts cycles spent in the current wait state
         if (w_waitEntry) begin
            r_tmo <= '0;
         end else if ((r_state == WAIT_BUSY) || (r_state == WAIT_DONE)) begin
            r_tmo <= r_tmo + 1'b1;
         end
         if ((r_state == WAIT_DONE) && fsmDone) begin
            r_sample <= fsmCycles;
         end
         if (r_state == ACCUM) begin
            r_acc <= r_acc + ACC_W'(r_sample);
            r_n   <= r_n + 1'b1;
         end
         if (r_state == REPORT) begin
            r_result <= w_avg;
            r_valid  <= 1'b1;
            r_hi     <= (w_avg > thrHigh);
            r_lo     <= (w_avg < thrLow);
         end
         if (w_abort) begin
            r_err <= 1'b1;
         end else if (clrErr) begin
            r_err <= 1'b0;
         end
      end
   end

   assign fsmStart    = (r_state == KICK);
   assign busy        = (r_state != IDLE);
   assign result      = r_result;
   assign resultValid = r_valid;
   assign alarmHigh   = r_hi;
   assign alarmLow    = r_lo;
   assign timeoutErr  = r_err;

`ifdef TEMP_SCHED_MINMAX_EN
   logic [WIDTH-1:0] r_min;
   logic [WIDTH-1:0] r_max;
   logic             r_first;
   logic             w_rep;

   assign w_rep = (r_state == REPORT);

   always_ff @(posedge lfClk) begin
      if (rst) begin
         r_min   <= '0;
         r_max   <= '0;
         r_first <= 1'b1;
      end else if (w_rep && (r_first || clrMinMax)) begin
         r_min   <= w_avg;
         r_max   <= w_avg;
         r_first <= 1'b0;
      end else if (w_rep) begin
         if (w_avg < r_min) r_min <= w_avg;
         if (w_avg > r_max) r_max <= w_avg;
      end else if (clrMinMax) begin
         r_min   <= '0;
         r_max   <= '0;
         r_first <= 1'b1;
      end
   end

   assign minResult = r_min;
   assign maxResult = r_max;
`endif

endmodule

// File: tb/tb_temp_meas_sched.sv
// Directed bench for temp_meas_sched with a behavioural tempFsm/counter stub.
// Min/max checks compile in only with TEMP_SCHED_MINMAX_EN.
module tb_temp_meas_sched;

   localparam int W   = 10;
   localparam int IW  = 16;
   localparam int L2  = 2;
   localparam int TMO = 16;

   logic          lfClk = 1'b0;
   logic          rst = 1'b1;
   logic          enable = 1'b0;
   logic          trigger = 1'b0;
   logic [IW-1:0] interval = '0;
   logic [W-1:0]  thrHigh = 10'd500;
   logic [W-1:0]  thrLow = 10'd10;
   logic          clrErr = 1'b0;
   logic          fsmDone = 1'b1;
   logic [W-1:0]  fsmCycles = '0;
   logic          fsmStart;
   logic          busy;
   logic [W-1:0]  result;
   logic          resultValid;
   logic          alarmHigh;
   logic          alarmLow;
   logic          timeoutErr;
`ifdef TEMP_SCHED_MINMAX_EN
   logic          clrMinMax = 1'b0;
   logic [W-1:0]  minResult;
   logic [W-1:0]  maxResult;
`endif

   int checks = 0;
   int errors = 0;

   temp_meas_sched #(
      .WIDTH(W), .INTERVAL_W(IW), .LOG2_NAVG(L2), .TIMEOUT(TMO)
   ) dut (
      .lfClk(lfClk), .rst(rst), .enable(enable), .trigger(trigger),
      .interval(interval), .thrHigh(thrHigh), .thrLow(thrLow),
      .clrErr(clrErr), .fsmDone(fsmDone), .fsmCycles(fsmCycles),
      .fsmStart(fsmStart), .busy(busy), .result(result),
      .resultValid(resultValid), .alarmHigh(alarmHigh),
      .alarmLow(alarmLow), .timeoutErr(timeoutErr)
`ifdef TEMP_SCHED_MINMAX_EN
      , .clrMinMax(clrMinMax), .minResult(minResult),
      .maxResult(maxResult)
`endif
   );

   always #5 lfClk = ~lfClk;

   // tempFsm stub: done falls 2 cycles and rises 5 cycles after the start pulse
   logic         stubHold = 1'b0;
   int           sidx = 0;
   int           scnt = 0;
   logic [W-1:0] samp [16];

   always @(posedge lfClk) begin
      if (!stubHold && fsmStart) begin
         scnt <= 1;
      end else if (scnt == 1) begin
         fsmDone <= 1'b0;
         scnt    <= 2;
      end else if (scnt == 4) begin
         fsmDone   <= 1'b1;
         fsmCycles <= samp[sidx % 16];
         sidx      <= sidx + 1;
         scnt      <= 0;
      end else if (scnt != 0) begin
         scnt <= scnt + 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d exp %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge lfClk);
      #1;
   endtask

   task automatic set4(input int a, input int b, input int c, input int d);
      samp[(sidx + 0) % 16] = W'(a);
      samp[(sidx + 1) % 16] = W'(b);
      samp[(sidx + 2) % 16] = W'(c);
      samp[(sidx + 3) % 16] = W'(d);
   endtask

   // Runs until the DUT has been idle 4 cycles after going busy.
   task automatic run(input int t1, input int t2, input int t3,
                      output int nst, output int nv,
                      output logic [W-1:0] lastRes);
      int quiet;
      bit seen;
      quiet = 0;
      seen = 0;
      nst = 0;
      nv = 0;
      lastRes = result;
      for (int c = 0; c < 300; c++) begin
         tick();
         if (fsmStart) nst++;
         if (resultValid) begin
            nv++;
            lastRes = result;
         end
         if (busy) begin
            seen = 1;
            quiet = 0;
         end else if (seen) begin
            quiet++;
         end
         trigger = (c == t1) || (c == t2) || (c == t3);
         if (seen && quiet >= 4) break;
      end
      trigger = 1'b0;
      chk("run_done", quiet, 4);
   endtask

   task automatic burst4(input int a, input int b, input int c, input int d,
                         input int expRes, input bit expHi, input bit expLo);
      int nst, nv;
      logic [W-1:0] r;
      set4(a, b, c, d);
      run(0, -1, -1, nst, nv, r);
      chk("b_starts", nst, 4);
      chk("b_valid", nv, 1);
      chk("b_result", r, expRes);
      chk("b_hi", alarmHigh, expHi);
      chk("b_lo", alarmLow, expLo);
   endtask

   initial begin
      int nst, nv, nr, d1, d2, prevBusy, k;
      logic [W-1:0] r;
      int rises [8];
      for (int i = 0; i < 16; i++) samp[i] = W'(300);

      tick();
      tick();
      chk("rst_busy", busy, 0);
      chk("rst_start", fsmStart, 0);
      chk("rst_result", result, 0);
      chk("rst_valid", resultValid, 0);
      chk("rst_alarms", {alarmHigh, alarmLow}, 0);
      chk("rst_err", timeoutErr, 0);
      rst = 1'b0;
      tick();

      // basic burst: (100+101+102+105)/4 = 102
      burst4(100, 101, 102, 105, 102, 0, 0);
      chk("t1_busy", busy, 0);

      // threshold boundaries
      thrHigh = 10'd200;
      thrLow  = 10'd50;
      burst4(200, 200, 202, 203, 201, 1, 0);
      burst4(49, 50, 50, 52, 50, 0, 0);
      burst4(49, 49, 49, 49, 49, 0, 1);

      // timeout: done stuck high
      stubHold = 1'b1;
      trigger = 1'b1;
      tick();
      trigger = 1'b0;
      for (int i = 0; i < 10 && !fsmStart; i++) tick();
      chk("tmo_kick", fsmStart, 1);
      nv = 0;
      for (int i = 1; i <= TMO; i++) begin
         tick();
         if (resultValid) nv++;
      end
      chk("tmo_early", timeoutErr, 0);
      chk("tmo_busy1", busy, 1);
      tick();
      if (resultValid) nv++;
      chk("tmo_err", timeoutErr, 1);
      chk("tmo_busy0", busy, 0);
      chk("tmo_result", result, 49);
      chk("tmo_alarm", alarmLow, 1);
      chk("tmo_novalid", nv, 0);
      stubHold = 1'b0;
      clrErr = 1'b1;
      tick();
      clrErr = 1'b0;
      chk("tmo_clr", timeoutErr, 0);

      // periodic mode
      thrHigh = 10'd1000;
      thrLow  = 10'd0;
      for (int i = 0; i < 16; i++) samp[i] = W'(300);
      enable = 1'b1;
      interval = 16'd50;
      nr = 0;
      prevBusy = 0;
      for (int c = 0; c < 200; c++) begin
         tick();
         if (busy && !prevBusy && nr < 8) begin
            rises[nr] = c;
            nr++;
         end
         prevBusy = busy;
      end
      chk("per_count", nr >= 3, 1);
      d1 = rises[1] - rises[0];
      d2 = rises[2] - rises[1];
      chk("per_gap1", d1, 50);
      chk("per_gap2", d2, 50);
      interval = '0;
      for (int c = 0; c < 60; c++) tick();
      nr = 0;
      prevBusy = busy;
      for (int c = 0; c < 150; c++) begin
         tick();
         if (busy && !prevBusy) nr++;
         prevBusy = busy;
      end
      chk("per_off", nr, 0);
      enable = 1'b0;

      // coalesced triggers: bursts 10,20,30,40 -> 25 then 4,4,4,8 -> 5
      thrLow = 10'd50;
      samp[(sidx + 0) % 16] = W'(10);
      samp[(sidx + 1) % 16] = W'(20);
      samp[(sidx + 2) % 16] = W'(30);
      samp[(sidx + 3) % 16] = W'(40);
      samp[(sidx + 4) % 16] = W'(4);
      samp[(sidx + 5) % 16] = W'(4);
      samp[(sidx + 6) % 16] = W'(4);
      samp[(sidx + 7) % 16] = W'(8);
      run(0, 10, 20, nst, nv, r);
      chk("co_starts", nst, 8);
      chk("co_valid", nv, 2);
      chk("co_result", r, 5);

      // reset in WAIT_DONE
      trigger = 1'b1;
      tick();
      trigger = 1'b0;
      for (int i = 0; i < 10 && !fsmStart; i++) tick();
      chk("mr_kick", fsmStart, 1);
      for (int i = 0; i < 3; i++) tick();
      rst = 1'b1;
      tick();
      chk("mr_busy", busy, 0);
      chk("mr_result", result, 0);
      chk("mr_valid", resultValid, 0);
      chk("mr_alarms", {alarmHigh, alarmLow}, 0);
      chk("mr_err", timeoutErr, 0);
      rst = 1'b0;
      k = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (busy) k++;
      end
      chk("mr_idle", k, 0);

`ifdef TEMP_SCHED_MINMAX_EN
      thrLow = 10'd0;
      burst4(80, 80, 80, 80, 80, 0, 0);
      burst4(120, 120, 120, 120, 120, 0, 0);
      burst4(90, 90, 90, 90, 90, 0, 0);
      chk("mm_min", minResult, 80);
      chk("mm_max", maxResult, 120);
      clrMinMax = 1'b1;
      tick();
      clrMinMax = 1'b0;
      chk("mm_clr", {minResult, maxResult}, 0);
      burst4(100, 100, 100, 100, 100, 0, 0);
      chk("mm_min2", minResult, 100);
      chk("mm_max2", maxResult, 100);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
